// File: rtl/tl_ram_pkg.sv
// Shared constants for the two-port TileLink-style RAM front end: opcodes,
// FSM encoding, default RAM size and the request legality rule.
package tl_ram_pkg;

    localparam int unsigned MEM_BYTES_DEF = 1024;

    localparam logic [2:0] A_PUT_FULL        = 3'd0;
    localparam logic [2:0] A_GET             = 3'd4;
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

    // A request must be a Put or Get of one aligned 8-byte word fully inside the RAM.
    function automatic logic req_legal(input logic [2:0] opcode, input logic [31:0] addr,
                                       input int unsigned mem_bytes);
        logic [32:0] end_addr;
        end_addr = {1'b0, addr} + 33'd8;
        return ((opcode == A_PUT_FULL) || (opcode == A_GET)) &&
               (addr[2:0] == 3'b000) && (end_addr <= {1'b0, mem_bytes});
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that was not served by the last accepted request.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic prio_q;  // requester that wins a tie
    logic prio_d;
    logic pick1;

    always_comb begin
        pick1   = req_i[1] & (~req_i[0] | prio_q);
        grant_o = {pick1, req_i[0] & ~pick1};
        prio_d  = prio_q;
        if (advance_i && (req_i != 2'b00)) begin
            prio_d = ~pick1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/tl_ram_arbiter.sv
// Arbitrates two TileLink-UL style requesters onto one single-port-pair RAM,
// one transaction in flight; illegal requests are answered with d_denied.
module tl_ram_arbiter
    import tl_ram_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned SRC_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid_0,
    input  logic             a_valid_1,
    output logic             a_ready_0,
    output logic             a_ready_1,
    input  logic [2:0]       a_opcode_0,
    input  logic [2:0]       a_opcode_1,
    input  logic [31:0]      a_address_0,
    input  logic [31:0]      a_address_1,
    input  logic [63:0]      a_data_0,
    input  logic [63:0]      a_data_1,
    input  logic [SRC_W-1:0] a_source_0,
    input  logic [SRC_W-1:0] a_source_1,
    output logic             d_valid_0,
    output logic             d_valid_1,
    input  logic             d_ready_0,
    input  logic             d_ready_1,
    output logic [2:0]       d_opcode_0,
    output logic [2:0]       d_opcode_1,
    output logic [63:0]      d_data_0,
    output logic [63:0]      d_data_1,
    output logic [SRC_W-1:0] d_source_0,
    output logic [SRC_W-1:0] d_source_1,
    output logic             d_denied_0,
    output logic             d_denied_1,
    output logic             ram_wen,
    output logic [31:0]      ram_waddr,
    output logic [63:0]      ram_wdata,
    output logic             ram_ren,
    output logic [31:0]      ram_raddr,
    input  logic [63:0]      ram_rdata,
    output state_e           dbg_state_o
);

    // Handshakes: an A beat transfers on a_valid & a_ready, a D beat on d_valid & d_ready;
    // d_* hold steady from d_valid rising until the D beat transfers.
    state_e           state_q;
    logic             owner_q;
    logic [1:0]       d_valid_q;
    logic [2:0]       d_opcode_q;
    logic [63:0]      d_data_q;
    logic [SRC_W-1:0] d_source_q;
    logic             d_denied_q;

    logic             idle;
    logic [1:0]       grant;
    logic             sel;
    logic             hs;
    logic             d_fire;
    logic [2:0]       req_opcode;
    logic [31:0]      req_addr;
    logic [63:0]      req_data;
    logic [SRC_W-1:0] req_source;
    logic             req_ok;

    // rst_n in the qualifier keeps a_ready and the RAM strobes low while reset is held.
    assign idle = rst_n && (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({a_valid_1, a_valid_0}),
        .advance_i (hs),
        .grant_o   (grant)
    );

    assign sel        = grant[1];
    assign hs         = idle && (grant != 2'b00);
    assign req_opcode = sel ? a_opcode_1  : a_opcode_0;
    assign req_addr   = sel ? a_address_1 : a_address_0;
    assign req_data   = sel ? a_data_1    : a_data_0;
    assign req_source = sel ? a_source_1  : a_source_0;
    assign req_ok     = req_legal(req_opcode, req_addr, MEM_BYTES);

    assign a_ready_0 = idle & grant[0];
    assign a_ready_1 = idle & grant[1];

    assign ram_wen   = hs && req_ok && (req_opcode == A_PUT_FULL);
    assign ram_ren   = hs && req_ok && (req_opcode == A_GET);
    assign ram_waddr = req_addr;
    assign ram_wdata = req_data;
    assign ram_raddr = req_addr;

    assign d_fire = (state_q == ST_RESP) && (owner_q ? d_ready_1 : d_ready_0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            d_valid_q  <= 2'b00;
            d_opcode_q <= '0;
            d_data_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        owner_q    <= sel;
                        d_source_q <= req_source;
                        d_opcode_q <= (req_opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
                        d_data_q   <= '0;
                        d_denied_q <= ~req_ok;
                        if (req_ok && (req_opcode == A_GET)) begin
                            state_q <= ST_RD_WAIT;
                        end else begin
                            state_q   <= ST_RESP;
                            d_valid_q <= {sel, ~sel};
                        end
                    end
                end
                ST_RD_WAIT: begin
                    d_data_q  <= ram_rdata;
                    d_valid_q <= {owner_q, ~owner_q};
                    state_q   <= ST_RESP;
                end
                ST_RESP: begin
                    if (d_fire) begin
                        d_valid_q <= 2'b00;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign d_valid_0   = d_valid_q[0];
    assign d_valid_1   = d_valid_q[1];
    assign d_opcode_0  = d_opcode_q;
    assign d_opcode_1  = d_opcode_q;
    assign d_data_0    = d_data_q;
    assign d_data_1    = d_data_q;
    assign d_source_0  = d_source_q;
    assign d_source_1  = d_source_q;
    assign d_denied_0  = d_denied_q;
    assign d_denied_1  = d_denied_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tl_ram_arbiter.sv
// Bench for tl_ram_arbiter: a RAM device, a transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_tl_ram_arbiter;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned SRC_W     = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             av[2];
    logic             ar[2];
    logic [2:0]       aop[2];
    logic [31:0]      aaddr[2];
    logic [63:0]      adata[2];
    logic [SRC_W-1:0] asrc[2];
    logic             dv[2];
    logic             dr[2];
    logic [2:0]       dop[2];
    logic [63:0]      ddata[2];
    logic [SRC_W-1:0] dsrc[2];
    logic             dden[2];
    logic             ram_wen, ram_ren;
    logic [31:0]      ram_waddr, ram_raddr;
    logic [63:0]      ram_wdata, ram_rdata;
    tl_ram_pkg::state_e dbg_state;

    tl_ram_arbiter #(.MEM_BYTES(MEM_BYTES), .SRC_W(SRC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid_0(av[0]), .a_valid_1(av[1]),
        .a_ready_0(ar[0]), .a_ready_1(ar[1]),
        .a_opcode_0(aop[0]), .a_opcode_1(aop[1]),
        .a_address_0(aaddr[0]), .a_address_1(aaddr[1]),
        .a_data_0(adata[0]), .a_data_1(adata[1]),
        .a_source_0(asrc[0]), .a_source_1(asrc[1]),
        .d_valid_0(dv[0]), .d_valid_1(dv[1]),
        .d_ready_0(dr[0]), .d_ready_1(dr[1]),
        .d_opcode_0(dop[0]), .d_opcode_1(dop[1]),
        .d_data_0(ddata[0]), .d_data_1(ddata[1]),
        .d_source_0(dsrc[0]), .d_source_1(dsrc[1]),
        .d_denied_0(dden[0]), .d_denied_1(dden[1]),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .dbg_state_o(dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM device: registered read data, valid the cycle after ram_ren.
    logic [63:0] ram_mem [128];
    logic [63:0] ref_mem [128];
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= ram_mem[ram_raddr[9:3]];
        if (ram_wen) ram_mem[ram_waddr[9:3]] = ram_wdata;
    end

    // Reference model: at most one outstanding response, which becomes visible
    // one cycle (Put / denied) or two cycles (good Get) after its A handshake.
    bit               m_pend = 0;
    int               m_port = 0;
    int               m_rcyc = 0;
    int               m_prio = 0;
    logic [2:0]       m_op;
    logic [63:0]      m_data;
    logic [SRC_W-1:0] m_src;
    bit               m_den;
    int               grant_log[$];
    int               ren_cnt = 0;
    int               wen_cnt = 0;

    always @(negedge clk) begin
        int  g;
        int  gi;
        bit  a_hs;
        bit  legal;
        bit  live;
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                check1("rst_a_ready", ar[p], 1'b0);
                check1("rst_d_valid", dv[p], 1'b0);
                check("rst_d_opcode", 64'(dop[p]), 64'd0);
                check("rst_d_data", ddata[p], 64'd0);
                check("rst_d_source", 64'(dsrc[p]), 64'd0);
                check1("rst_d_denied", dden[p], 1'b0);
            end
            check1("rst_ram_wen", ram_wen, 1'b0);
            check1("rst_ram_ren", ram_ren, 1'b0);
            check("rst_state", 64'(dbg_state), 64'(tl_ram_pkg::ST_IDLE));
            m_pend = 0;
            m_prio = 0;
        end else begin
            if (ram_wen) wen_cnt++;
            if (ram_ren) ren_cnt++;
            check1("ram_exclusive", ram_wen & ram_ren, 1'b0);
            live = m_pend && (cyc >= m_rcyc);
            for (int p = 0; p < 2; p++) begin
                check1("d_valid", dv[p], live && (m_port == p));
                if (live && (m_port == p)) begin
                    check("d_opcode", 64'(dop[p]), 64'(m_op));
                    check("d_data", ddata[p], m_data);
                    check("d_source", 64'(dsrc[p]), 64'(m_src));
                    check1("d_denied", dden[p], m_den);
                end
            end
            g = -1;
            if (!m_pend) begin
                if (av[0] && av[1]) g = m_prio;
                else if (av[0])     g = 0;
                else if (av[1])     g = 1;
            end
            for (int p = 0; p < 2; p++) check1("a_ready", ar[p], g == p);
            a_hs  = (g >= 0);
            gi    = a_hs ? g : 0;
            legal = a_hs && ((aop[gi] == 3'd0) || (aop[gi] == 3'd4)) && (aaddr[gi] % 8 == 0) &&
                    (longint'(aaddr[gi]) + 8 <= longint'(MEM_BYTES));
            check1("ram_wen", ram_wen, legal && (aop[gi] == 3'd0));
            check1("ram_ren", ram_ren, legal && (aop[gi] == 3'd4));
            if (legal && (aop[gi] == 3'd0)) begin
                check("ram_waddr", 64'(ram_waddr), 64'(aaddr[gi]));
                check("ram_wdata", ram_wdata, adata[gi]);
                ref_mem[int'(aaddr[gi] / 8)] = adata[gi];
            end
            if (legal && (aop[gi] == 3'd4)) check("ram_raddr", 64'(ram_raddr), 64'(aaddr[gi]));
            if (live && dr[m_port]) m_pend = 0;
            if (a_hs) begin
                grant_log.push_back(g);
                m_pend = 1;
                m_port = g;
                m_rcyc = cyc + ((legal && (aop[gi] == 3'd4)) ? 2 : 1);
                m_op   = (aop[gi] == 3'd4) ? 3'd1 : 3'd0;
                m_data = (legal && (aop[gi] == 3'd4)) ? ref_mem[int'(aaddr[gi] / 8)] : 64'd0;
                m_src  = asrc[gi];
                m_den  = !legal;
                m_prio = 1 - g;
            end
        end
    end

    task automatic send(input int p, input logic [2:0] op, input logic [31:0] addr,
                        input logic [63:0] data, input logic [SRC_W-1:0] src, output int t_acc);
        @(posedge clk);
        #1;
        av[p] = 1'b1; aop[p] = op; aaddr[p] = addr; adata[p] = data; asrc[p] = src;
        t_acc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ar[p]) begin
                t_acc = cyc;
                break;
            end
        end
        if (t_acc < 0) check1("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        av[p] = 1'b0;
    endtask

    task automatic wait_resp(input int p, output int t_resp);
        t_resp = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dv[p]) begin
                t_resp = cyc;
                break;
            end
        end
        if (t_resp < 0) check1("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    int t0, t1, t2, t3, ta, ta2, tb, tb2;
    int ren0, wen0, nv;

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = {32'hC0DE_0000, i};
            ref_mem[i] = {32'hC0DE_0000, i};
        end
        for (int p = 0; p < 2; p++) begin
            av[p] = 1'b0; aop[p] = '0; aaddr[p] = '0; adata[p] = '0; asrc[p] = '0; dr[p] = 1'b1;
        end
        rst_n = 1'b0;
        av[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_a_ready0", ar[0], 1'b0);
        check1("reset_d_valid0", dv[0], 1'b0);
        av[0] = 1'b0;
        #2 rst_n = 1'b1;

        // Put then Get on port 0 at 0x10
        send(0, 3'd0, 32'h10, 64'h1122334455667788, 4'h5, t0);
        wait_resp(0, t1);
        check("put_latency", 64'(t1 - t0), 64'd1);
        check("put_opcode", 64'(dop[0]), 64'd0);
        check("put_source", 64'(dsrc[0]), 64'h5);
        check1("put_denied", dden[0], 1'b0);
        send(0, 3'd4, 32'h10, 64'd0, 4'h6, t0);
        wait_resp(0, t1);
        check("get_latency", 64'(t1 - t0), 64'd2);
        check("get_opcode", 64'(dop[0]), 64'd1);
        check("get_data", ddata[0], 64'h1122334455667788);

        // Both ports request continuously from reset
        reset_pulse();
        grant_log.delete();
        fork
            begin
                send(0, 3'd4, 32'h20, 64'd0, 4'h3, ta);
                send(0, 3'd4, 32'h28, 64'd0, 4'h4, ta2);
            end
            begin
                send(1, 3'd4, 32'h30, 64'd0, 4'h9, tb);
                send(1, 3'd4, 32'h38, 64'd0, 4'hA, tb2);
            end
        join
        repeat (4) @(posedge clk);
        check("rr_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() >= 4) begin
            check("rr_grant0", 64'(grant_log[0]), 64'd0);
            check("rr_grant1", 64'(grant_log[1]), 64'd1);
            check("rr_grant2", 64'(grant_log[2]), 64'd0);
            check("rr_grant3", 64'(grant_log[3]), 64'd1);
        end

        // Illegal requests and the last legal word
        ren0 = ren_cnt;
        wen0 = wen_cnt;
        send(0, 3'd4, 32'h3FC, 64'd0, 4'h1, t0);
        wait_resp(0, t1);
        check1("deny_3fc", dden[0], 1'b1);
        check("deny_latency", 64'(t1 - t0), 64'd1);
        send(1, 3'd4, 32'h11, 64'd0, 4'h2, t0);
        wait_resp(1, t1);
        check1("deny_misaligned", dden[1], 1'b1);
        send(0, 3'd2, 32'h20, 64'h55, 4'h3, t0);
        wait_resp(0, t1);
        check1("deny_opcode2", dden[0], 1'b1);
        check("deny_opcode2_op", 64'(dop[0]), 64'd0);
        send(1, 3'd4, 32'h400, 64'd0, 4'h4, t0);
        wait_resp(1, t1);
        check1("deny_400", dden[1], 1'b1);
        check("deny_data", ddata[1], 64'd0);
        check("deny_no_ren", 64'(ren_cnt - ren0), 64'd0);
        check("deny_no_wen", 64'(wen_cnt - wen0), 64'd0);
        send(1, 3'd0, 32'h3F8, 64'hDEADBEEF0BADF00D, 4'h2, t0);
        wait_resp(1, t1);
        check1("last_word_put_ok", dden[1], 1'b0);
        send(0, 3'd4, 32'h3F8, 64'd0, 4'hE, t0);
        wait_resp(0, t1);
        check("last_word_get", ddata[0], 64'hDEADBEEF0BADF00D);

        // Backpressure on port 1 while port 0 waits
        dr[1] = 1'b0;
        fork
            begin
                send(1, 3'd0, 32'h40, 64'h0123456789ABCDEF, 4'hC, t0);
                wait_resp(1, t1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check1("stall_valid", dv[1], 1'b1);
                    check("stall_source", 64'(dsrc[1]), 64'hC);
                    check("stall_opcode", 64'(dop[1]), 64'd0);
                    check("stall_data", ddata[1], 64'd0);
                    check1("stall_a_ready0", ar[0], 1'b0);
                end
                @(posedge clk);
                #1 dr[1] = 1'b1;
            end
            begin
                repeat (2) @(posedge clk);
                send(0, 3'd4, 32'h40, 64'd0, 4'h1, t2);
            end
        join
        wait_resp(0, t3);
        check("after_stall_data", ddata[0], 64'h0123456789ABCDEF);
        check("after_stall_wait", 64'(t2 - t0 >= 7), 64'd1);

        // Reset while a Get sits in RD_WAIT
        send(0, 3'd4, 32'h10, 64'd0, 4'h7, t0);
        rst_n = 1'b0;
        #1;
        check("rd_wait_rst_state", 64'(dbg_state), 64'(tl_ram_pkg::ST_IDLE));
        check1("rd_wait_rst_dv0", dv[0], 1'b0);
        check1("rd_wait_rst_ar0", ar[0], 1'b0);
        check1("rd_wait_rst_ren", ram_ren, 1'b0);
        check("rd_wait_rst_data", ddata[0], 64'd0);
        check("rd_wait_rst_src", 64'(dsrc[0]), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (dv[0] || dv[1]) nv++;
        end
        check("rd_wait_no_resp", 64'(nv), 64'd0);
        send(1, 3'd4, 32'h10, 64'd0, 4'h8, t0);
        wait_resp(1, t1);
        check("post_rst_latency", 64'(t1 - t0), 64'd2);
        check("post_rst_data", ddata[1], 64'h1122334455667788);
        check("post_rst_source", 64'(dsrc[1]), 64'h8);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tl_ram_arbiter.md
TL_RAM_ARBITER -- requirements
Module: tl_ram_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024: byte capacity of the attached RAM.
REQ-002 The block SHALL have parameter SRC_W, default 4: source-ID width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have ports a_valid_0/a_valid_1, input, 1 each: request valid from requester n.
REQ-006 The block SHALL have ports a_ready_0/a_ready_1, output, 1 each: request accepted.
REQ-007 The block SHALL have ports a_opcode_0/1, input, 3: opcode 0 = PutFullData, 4 = Get; all others unsupported.
REQ-008 The block SHALL have ports a_address_0/1 (input, 32), a_data_0/1 (input, 64) and a_source_0/1 (input, SRC_W).
REQ-009 The block SHALL have ports d_valid_0/1 (output, 1) and d_ready_0/1 (input, 1): response handshake.
REQ-010 The block SHALL have ports d_opcode_0/1 (output, 3), d_data_0/1 (output, 64), d_source_0/1 (output, SRC_W) and d_denied_0/1 (output, 1).
REQ-011 The block SHALL have ports ram_wen (output, 1), ram_waddr (output, 32) and ram_wdata (output, 64): RAM write port, byte address, 8 bytes little-endian.
REQ-012 The block SHALL have ports ram_ren (output, 1), ram_raddr (output, 32) and ram_rdata (input, 64): RAM read port; ram_rdata is registered and valid the cycle after ram_ren.

Function
REQ-013 The FSM SHALL have three states: IDLE, RD_WAIT and RESP; only one transaction is outstanding at a time.
REQ-014 In IDLE, a_ready SHALL be asserted only for the granted requester; an A handshake is a_valid & a_ready.
REQ-015 Arbitration SHALL be round-robin: with one valid requester, grant it; with both valid, grant the one not served last; the last-served pointer updates on each A handshake.
REQ-016 A request SHALL be legal only if the opcode is 0 or 4, address[2:0] = 0 and address + 8 <= MEM_BYTES.
REQ-017 On a legal Put handshake, ram_wen SHALL assert combinationally in that same cycle with the request address and data, and the FSM SHALL go to RESP.
REQ-018 On a legal Get handshake, ram_ren SHALL assert combinationally in that same cycle; the FSM SHALL go to RD_WAIT, capture ram_rdata on the next edge, then go to RESP.
REQ-019 On an illegal request, ram_wen and ram_ren SHALL remain 0 and the FSM SHALL go directly to RESP with d_denied = 1.
REQ-020 In RESP, d_valid SHALL be asserted only to the requester that issued the request; its outputs are d_opcode (0 = AccessAck for a Put, 1 = AccessAckData for a Get), d_source equal to the captured a_source, and d_data equal to the read data for a Get, else 0.
REQ-021 d_valid and all d_* outputs SHALL hold stable until d_ready; on d_valid & d_ready the FSM SHALL return to IDLE, and no A handshake is allowed in that same cycle.
REQ-022 Latency SHALL be: Put accepted at cycle T gives d_valid at T+1; Get accepted at T gives d_valid at T+2; both hold until d_ready.
REQ-023 The block SHALL drive ram_wen and ram_ren to 0 whenever not specified above; they are never both 1.
REQ-024 A request arriving while the FSM is not in IDLE SHALL see a_ready = 0 and be held by the requester.

Reset
REQ-025 Asserting rst_n low SHALL immediately force: state IDLE, pointer favouring requester 0, a_ready_*/d_valid_*/ram_wen/ram_ren = 0, and all captured data, d_* data fields and d_denied = 0.
REQ-026 Reset asserted mid-transaction SHALL drop that transaction with no response; a write already strobed to the RAM is not undone.

Structure
REQ-027 Opcode constants, FSM state encoding and the default MEM_BYTES SHALL live in shared package tl_ram_pkg.
REQ-028 Arbitration SHALL be a sub-module rr_arb2 (req[1:0], advance, grant[1:0], pointer register).

Verification
REQ-029 Put port 0 at 0x10 with data 0x1122334455667788, then Get port 0 at 0x10 -> AccessAck at T+1, then AccessAckData with d_data 0x1122334455667788 at T+2.
REQ-030 Both ports issue a Get continuously from reset -> grants in order 0,1,0,1, and each d_source echoes its request.
REQ-031 Get at 0x3FC (MEM_BYTES = 1024), Get at 0x11 and opcode 2 -> each yields d_denied = 1, with ram_ren/ram_wen never asserted.
REQ-032 Hold d_ready_1 = 0 for 5 cycles during a response -> d_* stay stable, and a_ready_0 stays 0 throughout.
REQ-033 Assert rst_n low in RD_WAIT -> all outputs are 0 at once, no d_valid follows, and the next request is served normally.
